// File: rtl/ncl_sync_pkg.sv
// ncl_sync_pkg: shared state encoding, dual-rail codes and defaults for the NCL sum capture block
package ncl_sync_pkg;
  typedef enum logic {WAIT_DATA, WAIT_NULL} state_t;
  localparam logic [1:0] NULL_CODE = 2'b00;
  localparam logic [1:0] DATA0 = 2'b01;
  localparam logic [1:0] DATA1 = 2'b10;
  localparam int DEF_SYNC_STAGES = 2;
endpackage

// File: rtl/ncl_sum_capture_if.sv
// ncl_sum_capture_if: dual-rail sum, completion ack and captured-value handshake
// NCL_SEQ_CHECK_EN adds the sticky seq_err flag
interface ncl_sum_capture_if #(parameter int WIDTH = 32);
  logic [2*WIDTH-1:0] sum_dr;
  logic [WIDTH-1:0] sum_ack;
  logic [WIDTH-1:0] out_data;
  logic out_valid;
  logic out_ready;
`ifdef NCL_SEQ_CHECK_EN
  logic seq_err;
  modport master(output sum_dr, out_ready, input sum_ack, out_data, out_valid, seq_err);
  modport slave(input sum_dr, out_ready, output sum_ack, out_data, out_valid, seq_err);
`else
  modport master(output sum_dr, out_ready, input sum_ack, out_data, out_valid);
  modport slave(input sum_dr, out_ready, output sum_ack, out_data, out_valid);
`endif
endinterface

// File: rtl/ncl_completion_detect.sv
// ncl_completion_detect: combinational DATA/NULL completeness of a dual-rail wavefront (11 digits count as neither)
module ncl_completion_detect
  import ncl_sync_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] sum_dr,
  output logic               all_data,
  output logic               all_null
);
  logic [WIDTH-1:0] is_data;
  logic [WIDTH-1:0] is_null;
  for (genvar k = 0; k < WIDTH; k++) begin : g_digit
    assign is_data[k] = (sum_dr[2*k+:2] == DATA0) || (sum_dr[2*k+:2] == DATA1);
    assign is_null[k] = sum_dr[2*k+:2] == NULL_CODE;
  end
  assign all_data = &is_data;
  assign all_null = &is_null;
endmodule

// File: rtl/ncl_sum_capture.sv
// ncl_sum_capture: captures NCL dual-rail sum wavefronts into a valid/ready buffer and drives completion ack.
// Optional NCL_SEQ_CHECK_EN adds a sticky seq_err for non-incrementing captures.
module ncl_sum_capture
  import ncl_sync_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input logic clk,
  input logic init,
  ncl_sum_capture_if.slave bus
);
  logic all_data, all_null;
  logic [SYNC_STAGES-1:0] data_sync, null_sync;
  logic [WIDTH-1:0] rail1, data_q;
  logic valid_q, take, cap;
  state_t state;
  ncl_completion_detect #(.WIDTH(WIDTH)) u_detect (
    .sum_dr(bus.sum_dr),
    .all_data(all_data),
    .all_null(all_null)
  );
  for (genvar k = 0; k < WIDTH; k++) begin : g_rail
    assign rail1[k] = bus.sum_dr[2*k+1];
  end
  // completeness flags arrive asynchronously from the NCL ring
  always_ff @(posedge clk or posedge init)
    if (init) begin
      data_sync <= '0;
      null_sync <= '0;
    end else begin
      data_sync <= {data_sync[SYNC_STAGES-2:0], all_data};
      null_sync <= {null_sync[SYNC_STAGES-2:0], all_null};
    end
  assign take = valid_q & bus.out_ready;
  assign cap = (state == WAIT_DATA) & data_sync[SYNC_STAGES-1] & (~valid_q | take);
  always_ff @(posedge clk or posedge init)
    if (init) begin
      state <= WAIT_DATA;
      valid_q <= 1'b0;
      data_q <= '0;
    end else begin
      state <= cap ? WAIT_NULL : (state == WAIT_NULL && null_sync[SYNC_STAGES-1]) ? WAIT_DATA : state;
      valid_q <= cap | (valid_q & ~take);
      data_q <= cap ? rail1 : data_q;
    end
  assign bus.sum_ack = {WIDTH{state == WAIT_NULL}};
  assign bus.out_valid = valid_q;
  assign bus.out_data = data_q;
`ifdef NCL_SEQ_CHECK_EN
  logic [WIDTH-1:0] last;
  logic seen, err;
  always_ff @(posedge clk or posedge init)
    if (init) begin
      last <= '0;
      seen <= 1'b0;
      err <= 1'b0;
    end else if (cap) begin
      last <= rail1;
      seen <= 1'b1;
      err <= err | (seen && rail1 != last + WIDTH'(1));
    end
  assign bus.seq_err = err;
`endif
endmodule

// File: tb/tb_ncl_sum_capture.sv
// tb_ncl_sum_capture: vector table, hand corner sequences and a randomized closed-loop counter with a scoreboard
module tb_ncl_sum_capture;
  localparam int W = 32;
  logic clk = 1'b0;
  logic init = 1'b1;
  int checks = 0;
  int errors = 0;
  bit mon = 1'b0;
  bit rnd_ready = 1'b0;
  logic [W-1:0] q[$];
  logic [W-1:0] cnt;
  logic [2*W-1:0] bad;
  typedef struct {
    logic [W-1:0] val;
    logic [W-1:0] exp;
  } vec_t;
  vec_t vecs[6];
  ncl_sum_capture_if #(.WIDTH(W)) bus ();
  ncl_sum_capture #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .init(init),
    .bus(bus)
  );
  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] enc(logic [W-1:0] v);
    logic [2*W-1:0] r;
    for (int k = 0; k < W; k++) r[2*k+:2] = v[k] ? 2'b10 : 2'b01;
    return r;
  endfunction

  task automatic chk(string nm, logic [W-1:0] got, logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // one falling edge; in closed loop also randomize ready and score accepted values
  task automatic tick();
    @(negedge clk);
    if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
    if (mon && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stream_extra got %h expected none", bus.out_data);
      end else chk("stream", bus.out_data, q.pop_front());
    end
  endtask

  task automatic wait_ack(logic lvl, int lim);
    int n = 0;
    while (bus.sum_ack[0] !== lvl && n < lim) begin
      tick();
      n++;
    end
    chk("ack_wait", bus.sum_ack, {W{lvl}});
  endtask

  // DATA wavefront then NULL, checking the 3-edge latency both ways
  task automatic wave(logic [W-1:0] v, logic [W-1:0] exp);
    bus.sum_dr = enc(v);
    tick(); chk("lat1_ack", bus.sum_ack, '0);
    tick(); chk("lat2_ack", bus.sum_ack, '0);
    tick(); chk("cap_ack", bus.sum_ack, '1);
    chk("cap_valid", W'(bus.out_valid), 1);
    chk("cap_data", bus.out_data, exp);
    bus.sum_dr = '0;
    tick(); chk("null1_ack", bus.sum_ack, '1);
    tick(); chk("null2_ack", bus.sum_ack, '1);
    tick(); chk("null3_ack", bus.sum_ack, '0);
  endtask

  task automatic stuck(logic [2*W-1:0] v, logic [W-1:0] fixed);
    bus.sum_dr = v;
    repeat (10) begin
      tick();
      chk("stuck_ack", bus.sum_ack, '0);
      chk("stuck_valid", W'(bus.out_valid), 0);
    end
    wave(fixed, fixed);
  endtask

  task automatic do_reset();
    tick();
    init = 1'b1;
    bus.sum_dr = '0;
    tick();
    init = 1'b0;
  endtask

  initial begin
    bus.sum_dr = '0;
    bus.out_ready = 1'b0;
    vecs[0] = '{32'h0000_0005, 32'h0000_0005};
    vecs[1] = '{32'h0000_0000, 32'h0000_0000};
    vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[3] = '{32'hA5A5_A5A5, 32'hA5A5_A5A5};
    vecs[4] = '{32'h8000_0001, 32'h8000_0001};
    vecs[5] = '{32'h1234_5678, 32'h1234_5678};
    repeat (120) begin
      bus.sum_dr = {$urandom, $urandom};
      bus.out_ready = 1'($urandom_range(0, 1));
      tick();
      chk("rst_ack", bus.sum_ack, '0);
      chk("rst_valid", W'(bus.out_valid), 0);
      chk("rst_data", bus.out_data, '0);
    end
    bus.sum_dr = '0;
    bus.out_ready = 1'b1;
    tick();
    init = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) wave(vecs[i].val, vecs[i].exp);
    // backpressure: buffered 5 blocks capture of 6 until ready returns
    bus.out_ready = 1'b0;
    wave(32'h5, 32'h5);
    bus.sum_dr = enc(32'h6);
    repeat (6) begin
      tick();
      chk("bp_ack", bus.sum_ack, '0);
      chk("bp_valid", W'(bus.out_valid), 1);
      chk("bp_data", bus.out_data, 32'h5);
    end
    bus.out_ready = 1'b1;
    tick();
    chk("bp_cap_ack", bus.sum_ack, '1);
    chk("bp_cap_valid", W'(bus.out_valid), 1);
    chk("bp_cap_data", bus.out_data, 32'h6);
    bus.sum_dr = '0;
    repeat (3) tick();
    chk("bp_null_ack", bus.sum_ack, '0);
    chk("bp_drained", W'(bus.out_valid), 0);
    bad = enc(32'h7);
    bad[7:6] = 2'b11;
    stuck(bad, 32'h7);
    bad = enc(32'h9);
    bad[63:62] = 2'b00;
    stuck(bad, 32'h9);
    // asynchronous reset while acknowledging
    bus.sum_dr = enc(32'h11);
    repeat (3) tick();
    chk("pre_rst_ack", bus.sum_ack, '1);
    #1 init = 1'b1;
    #1 chk("arst_ack", bus.sum_ack, '0);
    chk("arst_valid", W'(bus.out_valid), 0);
    chk("arst_data", bus.out_data, '0);
    bus.sum_dr = '0;
    tick();
    init = 1'b0;
    tick();
    // closed loop: bench plays the NCL counter, wrapping through zero
    do_reset();
    mon = 1'b1;
    rnd_ready = 1'b1;
    cnt = 32'hFFFF_FFF8;
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 3)) tick();
      bus.sum_dr = enc(cnt);
      q.push_back(cnt);
      cnt++;
      wait_ack(1'b1, 300);
      repeat ($urandom_range(0, 3)) tick();
      bus.sum_dr = '0;
      wait_ack(1'b0, 300);
    end
    rnd_ready = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    chk("drain", W'(q.size()), 0);
    mon = 1'b0;
`ifdef NCL_SEQ_CHECK_EN
    chk("loop_seq_err", W'(bus.seq_err), 0);
    do_reset();
    chk("seq_rst", W'(bus.seq_err), 0);
    wave(32'h10, 32'h10);
    chk("seq_first", W'(bus.seq_err), 0);
    wave(32'h12, 32'h12);
    chk("seq_gap", W'(bus.seq_err), 1);
    wave(32'h13, 32'h13);
    chk("seq_sticky", W'(bus.seq_err), 1);
    do_reset();
    chk("seq_clr", W'(bus.seq_err), 0);
    wave(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wave(32'h0, 32'h0);
    chk("seq_wrap", W'(bus.seq_err), 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
